// File: rtl/am_class_argmax.sv
// Final HDC inference stage: snapshots all class similarities and scans them one per cycle for the argmax.
// Optional ARGMAX_RUNNER_UP_EN adds second_similarity and margin outputs.
module am_class_argmax #(
    parameter int NUM_CLASSES = 26,
    parameter int SIM_W       = 13,
    parameter int IDX_W       = 5
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         start,
    input  logic [NUM_CLASSES*SIM_W-1:0] similarity_bus,
    output logic                         busy,
    output logic                         result_valid,
    output logic [IDX_W-1:0]             predicted_class,
    output logic [SIM_W-1:0]             best_similarity
`ifdef ARGMAX_RUNNER_UP_EN
    ,
    output logic [SIM_W-1:0]             second_similarity,
    output logic [SIM_W-1:0]             margin
`endif
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state_reg;
    logic [SIM_W-1:0] snap_reg [NUM_CLASSES];
    logic [SIM_W-1:0] bus_slice [NUM_CLASSES];
    logic [IDX_W-1:0] idx_reg;
    logic [SIM_W-1:0] best_val_reg;
    logic [IDX_W-1:0] best_idx_reg;
    logic [SIM_W-1:0] best_val_next;
    logic [IDX_W-1:0] best_idx_next;
    logic [SIM_W-1:0] cur_val;
    logic             cur_gt;
    logic             last_idx;
`ifdef ARGMAX_RUNNER_UP_EN
    logic [SIM_W-1:0] second_val_reg;
    logic [SIM_W-1:0] second_val_next;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_slice
            assign bus_slice[gi] = similarity_bus[gi*SIM_W +: SIM_W];
        end
    endgenerate

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        cur_val       = snap_reg[idx_reg];
        cur_gt        = cur_val > best_val_reg;
        last_idx      = (idx_reg == IDX_W'(NUM_CLASSES - 1));
        best_val_next = cur_gt ? cur_val : best_val_reg;
        best_idx_next = cur_gt ? idx_reg : best_idx_reg;
`ifdef ARGMAX_RUNNER_UP_EN
        second_val_next = second_val_reg;
        if (cur_gt)
            second_val_next = best_val_reg;
        else if (cur_val > second_val_reg)
            second_val_next = cur_val;
`endif
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg       <= IDLE;
            idx_reg         <= '0;
            best_val_reg    <= '0;
            best_idx_reg    <= '0;
            busy            <= 1'b0;
            result_valid    <= 1'b0;
            predicted_class <= '0;
            best_similarity <= '0;
            for (int i = 0; i < NUM_CLASSES; i++)
                snap_reg[i] <= '0;
`ifdef ARGMAX_RUNNER_UP_EN
            second_val_reg    <= '0;
            second_similarity <= '0;
            margin            <= '0;
`endif
        end else begin
            result_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NUM_CLASSES; i++)
                            snap_reg[i] <= bus_slice[i];
                        best_val_reg <= '0;
                        best_idx_reg <= '0;
                        idx_reg      <= '0;
                        busy         <= 1'b1;
                        state_reg    <= SCAN;
`ifdef ARGMAX_RUNNER_UP_EN
                        second_val_reg <= '0;
`endif
                    end
                end
                SCAN: begin
                    best_val_reg <= best_val_next;
                    best_idx_reg <= best_idx_next;
`ifdef ARGMAX_RUNNER_UP_EN
                    second_val_reg <= second_val_next;
`endif
                    if (last_idx) begin
                        // Results are loaded from the final compare so they are valid throughout DONE.
                        result_valid    <= 1'b1;
                        predicted_class <= best_idx_next;
                        best_similarity <= best_val_next;
`ifdef ARGMAX_RUNNER_UP_EN
                        second_similarity <= second_val_next;
                        margin            <= best_val_next - second_val_next;
`endif
                        state_reg <= DONE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/am_class_argmax.md
Name: am_class_argmax

Overview:
Downstream of the per-class associative-memory accumulators. Once accumulation is finished and the accumulators are holding, this block snapshots all NUM_CLASSES similarity values in a single cycle. It then scans them sequentially, one class per cycle, to find the class with the highest similarity. It reports the winning class index and its similarity with a one-cycle valid pulse. This is the final inference stage of the HDC classifier.

Parameters:
NUM_CLASSES, 26, number of class hypervectors / similarity inputs (>=2)
SIM_W, 13, width of each similarity value (matches accumulator output)
IDX_W, 5, width of class index output; must satisfy 2**IDX_W >= NUM_CLASSES

Ports:
clk  input  1  clock
nrst  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse: similarities are final; begin argmax
similarity_bus  input  NUM_CLASSES*SIM_W  packed similarities; class i at bits [i*SIM_W +: SIM_W]
busy  output  1  high from the cycle after an accepted start until result_valid deasserts
result_valid  output  1  one-cycle pulse; result outputs are valid
predicted_class  output  IDX_W  index of the winning class
best_similarity  output  SIM_W  similarity of the winning class

Behaviour:
- Reset: nrst is asynchronous and active-low; clock is clk. Reset clears all registers and forces state IDLE, busy=0, result_valid=0, predicted_class=0, best_similarity=0, scan index=0, and the snapshot to 0.
- States: IDLE, SCAN, DONE.
- IDLE: start=1 at edge T0 does the following:
  - copies similarity_bus into the snapshot register;
  - sets best_val=0, best_idx=0, idx=0;
  - moves to SCAN.
- SCAN: at each edge, compare snap[idx] with best_val.
  - If strictly greater: best_val<=snap[idx], best_idx<=idx.
  - idx increments by 1.
  - When idx==NUM_CLASSES-1 is processed, move to DONE. This happens at edge T(NUM_CLASSES).
- DONE: lasts one cycle.
  - result_valid=1.
  - predicted_class and best_similarity are driven from best_idx and best_val.
  - Next edge returns to IDLE.
- Latency: from start sampled at T0, result_valid is high in the cycle after T(NUM_CLASSES), i.e. NUM_CLASSES+1 edges after start. Default is 27.
- Outputs hold their last result after DONE until the next DONE overwrites them. They do not clear on start.
- busy is 1 in SCAN and DONE, and 0 in IDLE.
- Ties: strict comparison, so the lowest index among equal maxima wins. If all values are 0, the result is class 0 with similarity 0.
- start while in SCAN or DONE is ignored: no restart, no snapshot update.
- start in the same cycle that DONE returns to IDLE is ignored (state is not IDLE at that edge).
- similarity_bus may change freely after T0; only the snapshot is used.
- Comparison is unsigned over the full SIM_W bits. The scan index never wraps: it stops at NUM_CLASSES-1.
- nrst asserted mid-scan aborts immediately. No result_valid is produced and outputs return to reset values.

Optional Feature:
Macro ARGMAX_RUNNER_UP_EN.
- Defined: adds output ports second_similarity (SIM_W) and margin (SIM_W), both reset to 0.
- During SCAN, the block also tracks second_val, initialised to 0 at T0:
  - if v > best_val: second_val<=best_val, then best updates as normal;
  - else if v > second_val: second_val<=v (so a tie with best_val sets second_val=v).
- In DONE: second_similarity=second_val and margin=best_val-second_val, which never underflows. Both are held like the other results.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
1. Reset, then start with class i = i*10 (class 25 = 250) -> result_valid exactly 27 cycles after start; predicted_class=25, best_similarity=250; busy high 27 cycles.
2. All zeros except class 7 = 4999 -> predicted_class=7, best_similarity=4999; change similarity_bus one cycle after start -> result unchanged.
3. Tie: classes 3 and 12 = 8191, all others 100 -> predicted_class=3, best_similarity=8191.
4. Second start pulses at cycles 5 and 27 after the first start -> both ignored; exactly one result_valid; busy never drops mid-scan.
5. nrst low 10 cycles into a scan, release, new start with class 0 = 1 and all others 0 -> no result from the aborted scan; new result predicted_class=0, best_similarity=1.
6. (ARGMAX_RUNNER_UP_EN) class 4 = 900, class 20 = 850, others 10 -> predicted_class=4, second_similarity=850, margin=50. Re-run with classes 4 and 20 both = 900 -> margin=0.
